dmem_store_checker: RTL
=======================

# dmem_store_checker

Synthesizable self-check responder on the data-memory write side of the single-cycle RISC-V core. It sits alongside the data memory on the `top` store interface (`dmem_write`, `dmem_addr`, `dmem_write_data`) and judges every store the core issues. It latches pass/fail with a failure code, counts cycles and stores, and enforces a timeout, so programs can be self-checked on FPGA without a simulator.

## Interface

Parameters:
- `RESULT_ADDR`, default 32'd100: address of the final-result store.
- `EXPECT_DATA`, default 32'd25: data value that must be stored at `RESULT_ADDR`.
- `SCRATCH_ADDR`, default 32'd96: address whose stores are always legal.
- `TIMEOUT_CYCLES`, default 1000: number of RUN cycles before a forced fail.
- `LOG_DEPTH`, default 4: store-log entries. Power of two. Used only when `STORE_LOG_EN` is defined.

Ports:
- `clk` (input, 1): rising-edge clock, shared with the core.
- `reset` (input, 1): asynchronous, active-high.
- `dmem_write` (input, 1): core store strobe.
- `dmem_addr` (input, 32): store address.
- `dmem_write_data` (input, 32): store data.
- `done` (output, 1): verdict reached. Sticky.
- `pass` (output, 1): correct result stored. Sticky.
- `fail_code` (output, 2): 0 none, 1 wrong result data, 2 illegal address, 3 timeout.
- `result` (output, 32): data captured from the verdict-causing store.
- `cycle_count` (output, 32): cycles spent in RUN.
- `store_count` (output, 16): legal stores accepted.
- `log_rd` (input, 1): pop one log entry. Present only with `STORE_LOG_EN`.
- `log_addr` (output, 32): address at the log head. Present only with `STORE_LOG_EN`.
- `log_empty` (output, 1): log has no entries. Present only with `STORE_LOG_EN`.

## Operation

- FSM states: IDLE, RUN, PASS, FAIL.
- IDLE: entered on reset. Moves to RUN unconditionally on the first clock edge after `reset` deasserts. The core's first fetch happens in this cycle, and any store in this cycle is ignored.
- RUN: each cycle, increment `cycle_count`. The following are evaluated in priority order:
  1. `dmem_write` and `dmem_addr == RESULT_ADDR`:
     - If `dmem_write_data == EXPECT_DATA`, go to PASS.
     - Otherwise, go to FAIL with code 1.
     - In both cases, `result` is loaded with `dmem_write_data`.
  2. `dmem_write` and `dmem_addr == SCRATCH_ADDR`, or any other address at or below `SCRATCH_ADDR`: accepted. Increment `store_count`.
  3. `dmem_write` at any other address: go to FAIL with code 2. `result` is loaded with `dmem_write_data`.
  4. `cycle_count == TIMEOUT_CYCLES-1`: go to FAIL with code 3. `result` is set to 0.
- Simultaneous events: a store and the timeout in the same cycle → the store is judged and the timeout is ignored.
- PASS / FAIL: terminal until reset.
  - All counters freeze.
  - Further stores are ignored and do not change `result`.
  - `done` = 1. `pass` = 1 only in PASS.
- Saturation: `store_count` saturates at 16'hFFFF. `cycle_count` cannot wrap because the timeout fires first.
- All comparisons are on the full 32 bits. There is no byte/halfword decode.

## Timing

- Reset values: `done`=0, `pass`=0, `fail_code`=0, `result`=0, `cycle_count`=0, `store_count`=0, `log_empty`=1, `log_addr`=0.
- Inputs are sampled on the same rising edge at which the data memory commits the store.
- All outputs are registered. A verdict is visible one cycle after the store edge.
- `reset` asserted mid-run clears state immediately, without waiting for a clock edge. Release follows the IDLE → RUN sequence above.
- `log_rd` takes effect on the edge. `log_addr` shows the next head entry the following cycle.

## Configuration

- `STORE_LOG_EN` defined:
  - Each accepted store in RUN (case 2 above) pushes `dmem_addr` into a `LOG_DEPTH`-deep FIFO.
  - When the FIFO is full, the oldest entry is dropped. Pushes are never lost.
  - A simultaneous push and pop is allowed. When full, the push overwrites and the pop advances once.
  - `log_rd` while the FIFO is empty is ignored.
- `STORE_LOG_EN` undefined: the log ports and FIFO are absent. Behaviour is otherwise identical.

## Structure

- Shared package `riscv_check_pkg`:
  - FSM state enum `chk_state_t`.
  - Fail-code enum `fail_code_t` (`FAIL_NONE`, `FAIL_DATA`, `FAIL_ADDR`, `FAIL_TIMEOUT`).
  - Default address/data constants.
- Sub-module `store_log_fifo`: a circular buffer with pointers one bit wider than the index, overwrite-on-full. Instantiated only under `STORE_LOG_EN`.

## Test plan

- Reset release, then stores to 96 (data 7), then 100 (data 25) → `pass`=1, `done`=1, `fail_code`=0, `result`=25, `store_count`=1, one cycle after the second store.
- Store to 100 with data 24 → `fail_code`=1, `result`=24, `pass`=0. A later store of 25 to 100 changes nothing.
- Store to 104 with data 25 → `fail_code`=2, `store_count` unchanged.
- No stores for 1000 RUN cycles → `fail_code`=3, `cycle_count`=999 frozen. With `TIMEOUT_CYCLES`=8, a store of 25 to 100 on the 8th RUN cycle → PASS, not timeout.
- `reset` pulsed asynchronously between clock edges after PASS → all outputs return to reset values before the next edge, and the checker re-enters RUN one cycle after release.
- `STORE_LOG_EN`: six accepted stores to addresses 0, 4, 8, 12, 16, 20 → popping returns 8, 12, 16, 20, then `log_empty`=1.

Source files
------------

// File: rtl/riscv_check_pkg.sv
// Shared types and defaults for the data-memory store checker.
package riscv_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } chk_state_t;

    typedef enum logic [1:0] {
        FAIL_NONE    = 2'd0,
        FAIL_DATA    = 2'd1,
        FAIL_ADDR    = 2'd2,
        FAIL_TIMEOUT = 2'd3
    } fail_code_t;

    localparam logic [31:0] DEF_RESULT_ADDR    = 32'd100;
    localparam logic [31:0] DEF_EXPECT_DATA    = 32'd25;
    localparam logic [31:0] DEF_SCRATCH_ADDR   = 32'd96;
    localparam int          DEF_TIMEOUT_CYCLES = 1000;
    localparam int          DEF_LOG_DEPTH      = 4;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/store_log_fifo.sv
// Circular address log that drops its oldest entry when a push arrives while full.
module store_log_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         empty
);
    localparam int IW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [IW:0]  wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic         is_empty, is_full, do_pop, rd_adv;
    logic [W-1:0] head_d;

    always_comb begin
        is_empty = (wr_ptr == rd_ptr);
        is_full  = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
        do_pop   = pop && !is_empty;
        // Overwrite-on-full and a pop both retire the head, but only once together.
        rd_adv   = do_pop || (push && is_full);
        wr_ptr_d = wr_ptr + (IW+1)'(push);
        rd_ptr_d = rd_ptr + (IW+1)'(rd_adv);
        if (push && (wr_ptr[IW-1:0] == rd_ptr_d[IW-1:0]))
            head_d = push_data;
        else
            head_d = mem[rd_ptr_d[IW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[IW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            head   <= '0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_d;
            rd_ptr <= rd_ptr_d;
            empty  <= (wr_ptr_d == rd_ptr_d);
            if (wr_ptr_d != rd_ptr_d)
                head <= head_d;
        end
    end

endmodule

// File: rtl/dmem_store_checker.sv
// Judges every core store: latches pass/fail with a code, counts cycles/stores, enforces a timeout.
// Optional store-address log enabled by defining STORE_LOG_EN.
module dmem_store_checker
    import riscv_check_pkg::*;
#(
    parameter logic [31:0] RESULT_ADDR    = DEF_RESULT_ADDR,
    parameter logic [31:0] EXPECT_DATA    = DEF_EXPECT_DATA,
    parameter logic [31:0] SCRATCH_ADDR   = DEF_SCRATCH_ADDR,
    parameter int          TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int          LOG_DEPTH      = DEF_LOG_DEPTH
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_write,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_write_data,
    output logic        done,
    output logic        pass,
    output logic [1:0]  fail_code,
    output logic [31:0] result,
    output logic [31:0] cycle_count,
    output logic [15:0] store_count
`ifdef STORE_LOG_EN
    ,
    input  logic        log_rd,
    output logic [31:0] log_addr,
    output logic        log_empty
`endif
);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    chk_state_t  state_q, state_d;
    fail_code_t  fail_code_q, code_d;
    logic        code_ld, result_ld, store_acc, cycle_inc;
    logic [31:0] result_d;

    always_comb begin
        state_d   = state_q;
        code_d    = FAIL_NONE;
        code_ld   = 1'b0;
        result_d  = '0;
        result_ld = 1'b0;
        store_acc = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_RUN;
            ST_RUN: begin
                // A store always wins over a timeout in the same cycle.
                if (dmem_write && (dmem_addr == RESULT_ADDR)) begin
                    result_d  = dmem_write_data;
                    result_ld = 1'b1;
                    if (dmem_write_data == EXPECT_DATA) begin
                        state_d = ST_PASS;
                    end else begin
                        state_d = ST_FAIL;
                        code_d  = FAIL_DATA;
                        code_ld = 1'b1;
                    end
                end else if (dmem_write && (dmem_addr <= SCRATCH_ADDR)) begin
                    store_acc = 1'b1;
                end else if (dmem_write) begin
                    state_d   = ST_FAIL;
                    code_d    = FAIL_ADDR;
                    code_ld   = 1'b1;
                    result_d  = dmem_write_data;
                    result_ld = 1'b1;
                end else if (cycle_count == TIMEOUT_LAST) begin
                    state_d   = ST_FAIL;
                    code_d    = FAIL_TIMEOUT;
                    code_ld   = 1'b1;
                    result_ld = 1'b1;
                end
            end
            default: state_d = state_q;
        endcase
        // The verdict cycle does not count, so the counter freezes at the deciding value.
        cycle_inc = (state_q == ST_RUN) && (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            fail_code_q <= FAIL_NONE;
            result      <= '0;
            cycle_count <= '0;
            store_count <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            state_q <= state_d;
            done    <= (state_d == ST_PASS) || (state_d == ST_FAIL);
            pass    <= (state_d == ST_PASS);
            if (code_ld)
                fail_code_q <= code_d;
            if (result_ld)
                result <= result_d;
            if (cycle_inc)
                cycle_count <= cycle_count + 32'd1;
            if (store_acc)
                store_count <= sat_inc16(store_count);
        end
    end

    assign fail_code = fail_code_q;

`ifdef STORE_LOG_EN
    store_log_fifo #(
        .DEPTH (LOG_DEPTH),
        .W     (32)
    ) u_log (
        .clk       (clk),
        .reset     (reset),
        .push      (store_acc),
        .push_data (dmem_addr),
        .pop       (log_rd),
        .head      (log_addr),
        .empty     (log_empty)
    );
`endif

endmodule
